// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for reg_write_arbiter: FSM state encoding,
// default sizing and the round-robin winner search.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;
  localparam int MAX_REQ   = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req_v at or after prio_v, wrapping within n requesters.
  function automatic pick_t rr_pick(input logic [7:0] req_v, input logic [2:0] prio_v,
                                    input int n);
    pick_t res;
    int    k;
    res.valid = 1'b0;
    res.idx   = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(prio_v) + i;
      if (k >= n) begin
        k = k - n;
      end else begin
        k = k;
      end
      if ((i < n) && !res.valid && req_v[k[2:0]]) begin
        res.valid = 1'b1;
        res.idx   = k[2:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_hold_reg.sv
// hold_reg: W-bit enable-gated storage register with synchronous active-high clear.
module hold_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         e,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage: clear on reset, load D when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (e) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one hold_reg among N_REQ writers.
// Optional macro ARB_LOCK_EN lets the current owner keep the register while lock is held.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  localparam int OW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  input  logic [N_REQ-1:0]   lock,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       q,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  state_t           state_r, state_s;
  logic [OW-1:0]    owner_r, owner_s;
  logic [OW-1:0]    prio_r, prio_s;
  logic [OW-1:0]    nprio_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [N_REQ-1:0] ack_r, ack_s;
  logic             busy_r, busy_s;
  logic [N_REQ-1:0] own_oh_s;
  logic [7:0]       pick_req_s;
  logic [2:0]       pick_prio_s;
  pick_t            pick_s;
  logic             keep_s;
  logic             we_s;
  logic [W-1:0]     wd_s;

`ifdef ARB_LOCK_EN
  assign keep_s = req[owner_r] & lock[owner_r];
`else
  logic unused_lock_s;
  assign unused_lock_s = ^lock;
  assign keep_s        = 1'b0;
`endif

  assign own_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_r;
  assign nprio_s  = (owner_r == OW'(N_REQ - 1)) ? {OW{1'b0}} : owner_r + OW'(1);
  assign we_s     = (state_r == GRANT);
  assign wd_s     = wdata[owner_r*W +: W];

  // Next-state, arbitration and registered-output preparation.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    prio_s      = prio_r;
    pick_req_s  = 8'd0;
    pick_prio_s = 3'd0;
    pick_s      = '{valid: 1'b0, idx: 3'd0};
    case (state_r)
      IDLE: begin
        pick_req_s[N_REQ-1:0] = req;
        pick_prio_s[OW-1:0]   = prio_r;
        pick_s                = rr_pick(pick_req_s, pick_prio_s, N_REQ);
        if (pick_s.valid) begin
          state_s = GRANT;
          owner_s = pick_s.idx[OW-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s = ACK;
      end
      ACK: begin
        if (keep_s) begin
          state_s = GRANT;
        end else begin
          // The owner just served is masked so another requester gets a turn.
          prio_s                = nprio_s;
          pick_req_s[N_REQ-1:0] = req & ~own_oh_s;
          pick_prio_s[OW-1:0]   = nprio_s;
          pick_s                = rr_pick(pick_req_s, pick_prio_s, N_REQ);
          if (pick_s.valid) begin
            state_s = GRANT;
            owner_s = pick_s.idx[OW-1:0];
          end else begin
            state_s = IDLE;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    grant_s = (state_s == GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_s) : {N_REQ{1'b0}};
    ack_s   = (state_s == ACK)   ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_s) : {N_REQ{1'b0}};
    busy_s  = (state_s != IDLE);
  end

  // FSM, priority/owner and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= {OW{1'b0}};
      prio_r  <= {OW{1'b0}};
      grant_r <= {N_REQ{1'b0}};
      ack_r   <= {N_REQ{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      prio_r  <= prio_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
    end
  end

  hold_reg #(.W(W)) u_hold (
    .clk   (clk),
    .reset (reset),
    .e     (we_s),
    .d     (wd_s),
    .q     (q)
  );

  assign grant = grant_r;
  assign ack   = ack_r;
  assign owner = owner_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   lock = '0;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   q;
  logic [1:0]     owner;
  logic           busy;

  int total = 0;
  int bad = 0;

  // Model: phase 0 = no write pending, 1 = writer driving, 2 = write acknowledged.
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_prio = 0;
  logic [W-1:0] m_q = '0;

  reg_write_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .lock(lock),
    .grant(grant), .ack(ack), .q(q), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_find(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Advance the model with the inputs present at the edge, then clock the DUT.
  task automatic tick();
    int w;
    logic [N-1:0] r;
    if (reset) begin
      m_phase = 0; m_owner = 0; m_prio = 0; m_q = '0;
    end else if (m_phase == 0) begin
      w = rr_find(req, m_prio);
      if (w >= 0) begin m_owner = w; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_q = wdata[m_owner*W +: W];
      m_phase = 2;
    end else begin
      if (LOCK && req[m_owner] && lock[m_owner]) begin
        m_phase = 1;
      end else begin
        m_prio = (m_owner + 1) % N;
        r = req;
        r[m_owner] = 1'b0;
        w = rr_find(r, m_prio);
        if (w >= 0) begin m_owner = w; m_phase = 1; end
        else m_phase = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; lock = '0;
    tick(); tick();
    total++;
    if (grant !== 4'b0 || ack !== 4'b0 || q !== 4'h0 || owner !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: grant=%b ack=%b q=%h owner=%0d busy=%b, required all zero",
               grant, ack, q, owner, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100; wdata = 16'h0A00;
    tick();
    total++;
    if (grant !== 4'b0100 || ack !== 4'b0 || busy !== 1'b1 || owner !== 2'd2) begin
      bad++;
      $display("FAIL single_grant: grant=%b ack=%b busy=%b owner=%0d, required 0100 0000 1 2",
               grant, ack, busy, owner);
    end
    tick();
    total++;
    if (q !== 4'hA || ack !== 4'b0100 || grant !== 4'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_ack: q=%h ack=%b grant=%b busy=%b, required a 0100 0000 1",
               q, ack, grant, busy);
    end
    req = '0;
    tick();
    total++;
    if (busy !== 1'b0 || ack !== 4'b0 || q !== 4'hA) begin
      bad++;
      $display("FAIL single_idle: busy=%b ack=%b q=%h, required 0 0000 a", busy, ack, q);
    end
  endtask

  task automatic test_all_four();
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; wdata = 16'h4321;
    for (int k = 0; k < N; k++) begin
      tick();
      total++;
      if (grant !== oh(k)) begin
        bad++;
        $display("FAIL all_grant%0d: grant=%b, required %b", k, grant, oh(k));
      end
      tick();
      total++;
      if (ack !== oh(k) || q !== 4'(k + 1)) begin
        bad++;
        $display("FAIL all_ack%0d: ack=%b q=%h, required %b %h", k, ack, q, oh(k), 4'(k + 1));
      end
      req[k] = 1'b0;
    end
    tick();
  endtask

  task automatic test_wrap();
    req = 4'b1001;
    tick();
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_first: grant=%b, required 0001", grant);
    end
    tick(); req[0] = 1'b0;
    tick();
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_second: grant=%b, required 1000", grant);
    end
    tick(); req = '0;
    tick();
  endtask

  task automatic test_drop_in_grant();
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0010; wdata = 16'h0050;
    tick();
    req = '0;
    tick();
    total++;
    if (q !== 4'h5 || ack !== 4'b0010) begin
      bad++;
      $display("FAIL drop_in_grant: q=%h ack=%b, required 5 0010", q, ack);
    end
    tick();
  endtask

  task automatic test_reset_in_grant();
    req = 4'b0100; wdata = 16'h0F00;
    tick();
    reset = 1'b1; req = '0;
    tick();
    total++;
    if (q !== 4'h0 || ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_in_grant: q=%h ack=%b grant=%b busy=%b owner=%0d, required all zero",
               q, ack, grant, busy, owner);
    end
    reset = 1'b0; req = 4'b1010;
    tick();
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL prio_after_reset: grant=%b, required 0010", grant);
    end
    tick(); req = '0;
    tick();
  endtask

  task automatic test_lock();
    int e;
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0011; lock = 4'b0001; wdata = 16'h0097;
    for (int w = 0; w < 3; w++) begin
      e = LOCK ? 0 : (w % 2);
      tick();
      total++;
      if (grant !== oh(e)) begin
        bad++;
        $display("FAIL lock_grant%0d: grant=%b, required %b", w, grant, oh(e));
      end
      tick();
      total++;
      if (ack !== oh(e)) begin
        bad++;
        $display("FAIL lock_ack%0d: ack=%b, required %b", w, ack, oh(e));
      end
    end
    lock = '0;
    tick();
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL lock_release: grant=%b, required 0010", grant);
    end
    tick(); req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg, ea;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      wdata = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      tick();
      eg = (m_phase == 1) ? oh(m_owner) : '0;
      ea = (m_phase == 2) ? oh(m_owner) : '0;
      total++;
      if (grant !== eg || ack !== ea || q !== m_q || owner !== 2'(m_owner) ||
          busy !== (m_phase != 0)) begin
        bad++;
        $display("FAIL random_c%0d: grant=%b ack=%b q=%h owner=%0d busy=%b, required %b %b %h %0d %b",
                 c, grant, ack, q, owner, busy, eg, ea, m_q, m_owner, (m_phase != 0));
      end
      for (int i = 0; i < N; i++) begin
        if (ea[i] && !(LOCK && lock[i])) req[i] = 1'b0;
      end
    end
    reset = 1'b0; req = '0; lock = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_drop_in_grant();
    test_reset_in_grant();
    test_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one W-bit enable-gated storage register among N_REQ requesters. The block wraps the register, drives its enable and data from the winning requester, and returns a one-cycle acknowledge when the write has landed. It sits between requesting logic and the shared register, replacing per-requester direct drive of E/D.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 4, data width of the shared register
- OW, $clog2(N_REQ), owner index width (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  write request per requester, level, held until ack
- wdata  input  N_REQ*W  write data, requester i at bits [i*W +: W]
- lock  input  N_REQ  keep-ownership request per requester (used only with ARB_LOCK_EN)
- grant  output  N_REQ  one-hot, current writer during GRANT
- ack  output  N_REQ  one-hot, one-cycle pulse when write is visible on q
- q  output  W  shared register contents
- owner  output  OW  index of last/current granted requester
- busy  output  1  high in GRANT and ACK

## Operation
- FSM states: IDLE, GRANT, ACK.
- IDLE: if any req bit set, select winner by round-robin search starting at prio, wrapping N_REQ-1 -> 0; register owner, go GRANT. Else stay IDLE.
- GRANT: grant[owner]=1; internal register E=1, D=wdata[owner]; q updates at end of cycle. Go ACK unconditionally, even if req[owner] dropped during GRANT (data sampled in GRANT cycle is written).
- ACK: ack[owner]=1 for exactly one cycle; prio <= owner+1 mod N_REQ. req[owner] is masked for arbitration this cycle. If any other req pending, select next winner (from new prio) and go directly to GRANT; else IDLE.
- Register E=0 in IDLE and ACK; q holds.
- Requester contract: deassert req the cycle after its ack, or its req is re-arbitrated normally from IDLE.
- Only one grant/ack bit ever high; grant and ack never high in the same cycle.

## Timing
- Reset values: state IDLE, q=0, grant=0, ack=0, owner=0, prio=0, busy=0.
- Latency: req high at edge n (IDLE) -> grant cycle n+1 -> q new and ack at cycle n+2.
- Throughput: back-to-back writes from different requesters every 2 cycles (ACK->GRANT).
- All N_REQ requesting from reset: service order 0,1,2,...,N_REQ-1,0.
- Reset asserted in GRANT: write discarded, q=0, no ack; next cycle IDLE.
- Reset asserted in ACK: ack suppressed in following cycle, prio back to 0.
- lock without macro: ignored entirely.

## Configuration
- ARB_LOCK_EN defined: in ACK, if req[owner] and lock[owner] both high, owner is not masked and not rotated; next state GRANT with same owner, prio unchanged. Allows a requester to stream writes every 2 cycles, starving others while lock held.
- ARB_LOCK_EN undefined: lock port present but unused; strict rotation as above.

## Structure
- Package reg_arb_pkg: state enum (IDLE, GRANT, ACK, 2-bit encoding 0/1/2), default N_REQ/W constants, round-robin pick function (req vector, prio -> index, valid).
- Sub-module hold_reg: W-bit register with clk, reset (sync, active-high, clears to 0), E, D, Q; q driven from its Q.
- Top holds FSM, prio/owner registers, wdata mux.

## Test plan
- Reset, single req=4'b0100, wdata[2]=4'hA -> grant=4'b0100 cycle 1, q=4'hA and ack=4'b0100 cycle 2, busy high cycles 1-2, IDLE cycle 3.
- req=4'b1111 held (each dropped after own ack), wdata i = 4'h1+i -> acks 0,1,2,3 every 2 cycles; q = 1,2,3,4.
- After owner 3 served, req=4'b1001 -> 0 wins (wrap) before 3.
- req[1] dropped during GRANT with wdata[1]=4'h5 -> q=4'h5, ack[1] still pulses.
- Reset high during GRANT of wdata=4'hF -> q=0, no ack, prio=0.
- ARB_LOCK_EN: req=4'b0011, lock=4'b0001 for 3 writes -> three acks to 0 consecutively, then lock=0 -> ack to 1 next; without macro -> alternating 0,1.
